// File: rtl/writeback_arbiter_pkg.sv
// Shared X->W types: the packed result record every execute unit hands to writeback.
// Field widths here must agree with the parameters of the blocks that carry the record.
package writeback_arbiter_pkg;

    localparam int XLEN           = 32;
    localparam int ARCH_ADDR_BITS = 5;
    localparam int NUM_UNITS      = 4;
    localparam int SEQ_NUM_BITS   = 5;
    localparam int PHYS_ADDR_BITS = 6;

    typedef struct packed {
        logic                      val;
        logic [XLEN-1:0]           pc;
        logic [SEQ_NUM_BITS-1:0]   seq_num;
        logic [ARCH_ADDR_BITS-1:0] waddr;
        logic [XLEN-1:0]           wdata;
        logic                      wen;
        logic [PHYS_ADDR_BITS-1:0] preg;
        logic [PHYS_ADDR_BITS-1:0] ppreg;
    } xw_result_t;

endpackage

// File: rtl/writeback_arbiter_rr_arbiter.sv
// Round-robin arbiter: scans req from the pointer upward, grants the first requester,
// and moves the pointer past the winner only when the grant is consumed (en_i).
module writeback_arbiter_rr_arbiter #(
    parameter int p_width = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [p_width-1:0] req_i,
    input  logic               en_i,
    output logic [p_width-1:0] gnt_o
);

    localparam int PTR_W = (p_width > 1) ? $clog2(p_width) : 1;

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] win;
    logic             found;

    always_comb begin : p_scan
        int idx;
        idx   = 0;
        gnt_o = '0;
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < p_width; k++) begin
            idx = (int'(ptr_q) + k) % p_width;
            if (!found && req_i[PTR_W'(idx)]) begin
                found               = 1'b1;
                win                 = PTR_W'(idx);
                gnt_o[PTR_W'(idx)]  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && found) begin
            ptr_d = (win == PTR_W'(p_width - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback receiver: round-robin pick among execute units, one registered entry that
// drives the register-file write port and the commit notification. Optional build macro
// WRITEBACK_X0_FILTER_EN forces wen low for entries targeting x0.
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int p_num_units      = NUM_UNITS,
    parameter int p_seq_num_bits   = SEQ_NUM_BITS,
    parameter int p_phys_addr_bits = PHYS_ADDR_BITS
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [p_num_units-1:0]                    X_val,
    output logic [p_num_units-1:0]                    X_rdy,
    input  logic [p_num_units*32-1:0]                 X_pc,
    input  logic [p_num_units*p_seq_num_bits-1:0]     X_seq_num,
    input  logic [p_num_units*5-1:0]                  X_waddr,
    input  logic [p_num_units*32-1:0]                 X_wdata,
    input  logic [p_num_units-1:0]                    X_wen,
    input  logic [p_num_units*p_phys_addr_bits-1:0]   X_preg,
    input  logic [p_num_units*p_phys_addr_bits-1:0]   X_ppreg,
    output logic                                      rf_wen,
    output logic [p_phys_addr_bits-1:0]               rf_preg,
    output logic [31:0]                               rf_wdata,
    output logic                                      C_val,
    input  logic                                      C_rdy,
    output logic [31:0]                               C_pc,
    output logic [p_seq_num_bits-1:0]                 C_seq_num,
    output logic [4:0]                                C_waddr,
    output logic [p_phys_addr_bits-1:0]               C_preg,
    output logic [p_phys_addr_bits-1:0]               C_ppreg,
    output logic                                      C_wen
);

    logic                   can_accept;
    logic                   xfer;
    logic [p_num_units-1:0] gnt;
    xw_result_t             sel;
    xw_result_t             entry_q;
    xw_result_t             entry_d;

    // A draining entry frees the slot in the same cycle, giving one transfer per clock.
    assign can_accept = !entry_q.val | (entry_q.val & C_rdy);
    assign xfer       = can_accept & (|X_val);
    assign X_rdy      = gnt & {p_num_units{can_accept}};

    writeback_arbiter_rr_arbiter #(
        .p_width (p_num_units)
    ) u_rr_arbiter (
        .clk   (clk),
        .rst   (rst),
        .req_i (X_val),
        .en_i  (can_accept),
        .gnt_o (gnt)
    );

    always_comb begin
        sel = '0;
        for (int u = 0; u < p_num_units; u++) begin
            if (gnt[u]) begin
                sel.val     = 1'b1;
                sel.pc      = X_pc[u*32 +: 32];
                sel.seq_num = X_seq_num[u*p_seq_num_bits +: p_seq_num_bits];
                sel.waddr   = X_waddr[u*5 +: 5];
                sel.wdata   = X_wdata[u*32 +: 32];
                sel.preg    = X_preg[u*p_phys_addr_bits +: p_phys_addr_bits];
                sel.ppreg   = X_ppreg[u*p_phys_addr_bits +: p_phys_addr_bits];
`ifdef WRITEBACK_X0_FILTER_EN
                sel.wen     = X_wen[u] & (X_waddr[u*5 +: 5] != 5'd0);
`else
                sel.wen     = X_wen[u];
`endif
            end
        end
    end

    always_comb begin
        entry_d = entry_q;
        if (xfer) begin
            entry_d = sel;
        end else if (C_rdy) begin
            entry_d.val = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign C_val     = entry_q.val;
    assign C_pc      = entry_q.pc;
    assign C_seq_num = entry_q.seq_num;
    assign C_waddr   = entry_q.waddr;
    assign C_preg    = entry_q.preg;
    assign C_ppreg   = entry_q.ppreg;
    assign C_wen     = entry_q.wen;

    assign rf_wen    = entry_q.val & C_rdy & entry_q.wen;
    assign rf_preg   = entry_q.preg;
    assign rf_wdata  = entry_q.wdata;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized scoreboard bench for writeback_arbiter: a transaction-level model predicts
// grants and commit order; a separate monitor checks every commit against the queue.
module tb_writeback_arbiter;

    localparam int N  = 4;
    localparam int SB = 5;
    localparam int PB = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      X_val;
    logic [N-1:0]      X_rdy;
    logic [N*32-1:0]   X_pc;
    logic [N*SB-1:0]   X_seq_num;
    logic [N*5-1:0]    X_waddr;
    logic [N*32-1:0]   X_wdata;
    logic [N-1:0]      X_wen;
    logic [N*PB-1:0]   X_preg;
    logic [N*PB-1:0]   X_ppreg;
    logic              rf_wen;
    logic [PB-1:0]     rf_preg;
    logic [31:0]       rf_wdata;
    logic              C_val;
    logic              C_rdy;
    logic [31:0]       C_pc;
    logic [SB-1:0]     C_seq_num;
    logic [4:0]        C_waddr;
    logic [PB-1:0]     C_preg;
    logic [PB-1:0]     C_ppreg;
    logic              C_wen;

    always #5 clk = ~clk;

    writeback_arbiter #(
        .p_num_units      (N),
        .p_seq_num_bits   (SB),
        .p_phys_addr_bits (PB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .X_val     (X_val),
        .X_rdy     (X_rdy),
        .X_pc      (X_pc),
        .X_seq_num (X_seq_num),
        .X_waddr   (X_waddr),
        .X_wdata   (X_wdata),
        .X_wen     (X_wen),
        .X_preg    (X_preg),
        .X_ppreg   (X_ppreg),
        .rf_wen    (rf_wen),
        .rf_preg   (rf_preg),
        .rf_wdata  (rf_wdata),
        .C_val     (C_val),
        .C_rdy     (C_rdy),
        .C_pc      (C_pc),
        .C_seq_num (C_seq_num),
        .C_waddr   (C_waddr),
        .C_preg    (C_preg),
        .C_ppreg   (C_ppreg),
        .C_wen     (C_wen)
    );

    typedef struct {
        logic [31:0]   pc;
        logic [SB-1:0] seq;
        logic [4:0]    waddr;
        logic [31:0]   wdata;
        logic          wen;
        logic [PB-1:0] preg;
        logic [PB-1:0] ppreg;
    } txn_t;

    txn_t   pend [N];
    bit     pend_val [N];
    txn_t   sb [$];
    int     checks = 0;
    int     errors = 0;
    int     seq_ctr = 0;
    int     mptr = 0;
    bit     mfull = 1'b0;
    int     acc = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic txn_t new_txn();
        txn_t t;
        t.pc    = $urandom;
        t.seq   = SB'(seq_ctr);
        seq_ctr = seq_ctr + 1;
        t.waddr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        t.wdata = $urandom;
        t.wen   = ($urandom_range(0, 3) != 0);
        t.preg  = PB'($urandom);
        t.ppreg = PB'($urandom);
        return t;
    endfunction

    function automatic logic exp_wen(input txn_t t);
`ifdef WRITEBACK_X0_FILTER_EN
        return t.wen && (t.waddr != 5'd0);
`else
        return t.wen;
`endif
    endfunction

    task automatic drive_units();
        X_val = '0; X_pc = '0; X_seq_num = '0; X_waddr = '0;
        X_wdata = '0; X_wen = '0; X_preg = '0; X_ppreg = '0;
        for (int u = 0; u < N; u++) begin
            X_val     = X_val     | (N'(pend_val[u]) << u);
            X_pc      = X_pc      | ((N*32)'(pend[u].pc) << (u*32));
            X_seq_num = X_seq_num | ((N*SB)'(pend[u].seq) << (u*SB));
            X_waddr   = X_waddr   | ((N*5)'(pend[u].waddr) << (u*5));
            X_wdata   = X_wdata   | ((N*32)'(pend[u].wdata) << (u*32));
            X_wen     = X_wen     | (N'(pend[u].wen) << u);
            X_preg    = X_preg    | ((N*PB)'(pend[u].preg) << (u*PB));
            X_ppreg   = X_ppreg   | ((N*PB)'(pend[u].ppreg) << (u*PB));
        end
    endtask

    // One clock: retire last accepted unit, offer new work, predict the grant and occupancy.
    task automatic step(input int gen_pct, input int rdy_pct, input bit gen_on);
        bit           full_before;
        bit           can;
        logic [N-1:0] exp_rdy;
        @(posedge clk);
        #1;
        if (acc >= 0) pend_val[acc] = 1'b0;
        for (int u = 0; u < N; u++) begin
            if (!pend_val[u] && gen_on && ($urandom_range(0, 99) < gen_pct)) begin
                pend[u]     = new_txn();
                pend_val[u] = 1'b1;
            end
        end
        drive_units();
        C_rdy       = ($urandom_range(0, 99) < rdy_pct);
        full_before = mfull;
        can         = !mfull || C_rdy;
        acc         = -1;
        if (can) begin
            for (int k = 0; k < N; k++) begin
                if (acc < 0 && pend_val[(mptr + k) % N]) acc = (mptr + k) % N;
            end
        end
        exp_rdy = (acc >= 0) ? (N'(1) << acc) : '0;
        if (acc >= 0) begin
            sb.push_back(pend[acc]);
            mptr  = (acc + 1) % N;
            mfull = 1'b1;
        end else if (C_rdy) begin
            mfull = 1'b0;
        end
        @(negedge clk);
        check("x_rdy", 64'(X_rdy), 64'(exp_rdy));
        check("c_val", 64'(C_val), 64'(full_before));
    endtask

    // Reset while an entry is held under backpressure; the entry must vanish unwritten.
    task automatic mid_reset();
        for (int i = 0; i < 20 && !mfull; i++) step(60, 0, 1'b1);
        step(60, 0, 1'b1);
        @(posedge clk);
        #1;
        if (acc >= 0) pend_val[acc] = 1'b0;
        rst   = 1'b0;
        C_rdy = 1'b0;
        X_val = '0;
        #1;
        check("rst_c_val", 64'(C_val), 64'd0);
        check("rst_rf_wen", 64'(rf_wen), 64'd0);
        sb.delete();
        mfull = 1'b0;
        mptr  = 0;
        acc   = -1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int u = 0; u < N; u += 2) begin
            if (!pend_val[u]) begin
                pend[u]     = new_txn();
                pend_val[u] = 1'b1;
            end
        end
    endtask

    // Commit-side monitor, independent of the stimulus process.
    initial begin
        txn_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && C_val === 1'b1 && C_rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL commit_unexpected actual=seq %0h required=no commit", C_seq_num);
                end else begin
                    e = sb.pop_front();
                    check("c_pc", 64'(C_pc), 64'(e.pc));
                    check("c_seq_num", 64'(C_seq_num), 64'(e.seq));
                    check("c_waddr", 64'(C_waddr), 64'(e.waddr));
                    check("c_preg", 64'(C_preg), 64'(e.preg));
                    check("c_ppreg", 64'(C_ppreg), 64'(e.ppreg));
                    check("c_wen", 64'(C_wen), 64'(exp_wen(e)));
                    check("rf_wen", 64'(rf_wen), 64'(exp_wen(e)));
                    if (exp_wen(e)) begin
                        check("rf_preg", 64'(rf_preg), 64'(e.preg));
                        check("rf_wdata", 64'(rf_wdata), 64'(e.wdata));
                    end
                end
            end else begin
                check("rf_wen_idle", 64'(rf_wen), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=still running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit busy;
        rst   = 1'b0;
        C_rdy = 1'b0;
        for (int u = 0; u < N; u++) begin
            pend_val[u] = 1'b0;
            pend[u]     = new_txn();
        end
        drive_units();
        repeat (3) @(posedge clk);
        #1;
        check("reset_c_val", 64'(C_val), 64'd0);
        check("reset_rf_wen", 64'(rf_wen), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        repeat (20)  step(100, 100, 1'b1);
        repeat (150) step(40, 70, 1'b1);
        mid_reset();
        repeat (150) step(80, 30, 1'b1);
        mid_reset();
        repeat (100) step(20, 90, 1'b1);

        busy = 1'b1;
        for (int i = 0; i < 60 && busy; i++) begin
            step(0, 100, 1'b0);
            busy = mfull;
            for (int u = 0; u < N; u++) if (pend_val[u]) busy = 1'b1;
        end
        @(negedge clk);
        check("drain_c_val", 64'(C_val), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writeback-stage receiver for the X->W handshake: the consumer end of the interface that every execute unit (ALU, iterative mul/div/rem, memory) drives.
- Arbitrates among p_num_units execute-unit producers with a round-robin policy.
- Registers the single winner, then drives the register-file write port and a commit/free notification toward the ROB and rename logic.
- One entry in flight; one transfer per cycle at full throughput.

Parameters:
- p_num_units, 4, number of execute units feeding writeback
- p_seq_num_bits, 5, width of the ROB sequence number
- p_phys_addr_bits, 6, width of the physical register index

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- X_val  in  p_num_units  per-unit result valid
- X_rdy  out  p_num_units  per-unit accept; one-hot or zero
- X_pc  in  p_num_units*32  per-unit PC
- X_seq_num  in  p_num_units*p_seq_num_bits  per-unit sequence number
- X_waddr  in  p_num_units*5  per-unit architectural destination
- X_wdata  in  p_num_units*32  per-unit result data
- X_wen  in  p_num_units  per-unit write enable
- X_preg  in  p_num_units*p_phys_addr_bits  per-unit destination physical register
- X_ppreg  in  p_num_units*p_phys_addr_bits  per-unit previous physical register, freed at commit
- rf_wen  out  1  register-file write enable
- rf_preg  out  p_phys_addr_bits  register-file write index
- rf_wdata  out  32  register-file write data
- C_val  out  1  commit notification valid
- C_rdy  in  1  commit consumer ready
- C_pc  out  32  committed PC
- C_seq_num  out  p_seq_num_bits  committed sequence number
- C_waddr  out  5  committed architectural destination
- C_preg  out  p_phys_addr_bits  committed physical register
- C_ppreg  out  p_phys_addr_bits  physical register to free
- C_wen  out  1  commit writes a register

Behaviour:
- Reset (rst low, asynchronous):
  - out_val=0, so C_val=0 and rf_wen=0.
  - Round-robin pointer = 0.
  - Other output fields are don't-care.
- Accept condition: can_accept = !out_val | (C_val & C_rdy).
  - A full entry draining in the same cycle permits a new accept.
  - Full throughput: one transfer per cycle.
- Arbitration:
  - Scan X_val starting at index ptr, wrapping modulo p_num_units.
  - The first valid unit is granted.
  - X_rdy[g] = can_accept & X_val[g]; all other X_rdy bits are 0.
  - X_rdy never depends on any unit's own val except through the grant; there is no combinational path from C_rdy to X_rdy other than via can_accept.
- Pointer update: on a transfer from unit g, ptr <= (g+1) mod p_num_units. With no transfer, ptr holds.
- Latency:
  - An X transfer at cycle N gives C_val=1 at N+1 with the registered fields.
  - Fields are held stable while C_val & !C_rdy.
- Register-file write:
  - rf_wen = C_val & C_rdy & C_wen.
  - rf_preg = C_preg; rf_wdata = registered wdata.
  - Exactly one write per committed entry, in the commit cycle.
- Simultaneous drain and fill: the new entry overwrites the register in the same edge; out_val stays 1.
- No valid inputs and a drain: out_val <= 0.
- Reset mid-operation: the in-flight entry is discarded and is not written.
- C_wen=0 entries, e.g. stores: C_val still asserts so the ROB can retire; rf_wen stays 0.

Optional Feature:
- Macro: WRITEBACK_X0_FILTER_EN.
- Defined: an entry with waddr==0 is captured with wen forced to 0. rf_wen never asserts for x0, and C_wen reads 0 for it.
- Undefined: wen passes through unchanged. Upstream must not request x0 writes.

Decomposition:
- Shared UArch package: a typedef for the packed X->W result struct (val, pc, seq_num, waddr, wdata, wen, preg, ppreg), reused by all execute units and this block.
- Sub-module: rr_arbiter. Parameterised width; inputs req vector and en; outputs one-hot grant; holds the pointer register. It is reusable by the issue logic.

Test Plan:
1. Single unit: unit 2 sends wdata=0xDEADBEEF, preg=0x11, wen=1 at cycle 5 with C_rdy=1 -> C_val=1 at cycle 6; rf_wen=1, rf_preg=0x11, rf_wdata=0xDEADBEEF for exactly one cycle.
2. Round-robin: all 4 units valid continuously, C_rdy=1 -> grants go 0,1,2,3,0 on consecutive cycles; X_rdy is one-hot each cycle.
3. Backpressure: C_rdy=0 for 3 cycles with an entry held and units 1 and 3 valid -> X_rdy=0, C fields stable, rf_wen=0. When C_rdy rises, the held entry commits, unit 1 is accepted the same cycle, and unit 3 is next.
4. Store retire: entry with wen=0, seq_num=7 -> C_val=1, C_seq_num=7, rf_wen=0.
5. Reset mid-flight: rst low while C_val=1 and C_rdy=0 -> C_val=0 and rf_wen=0 immediately. After release, the first grant goes to unit 0 if it is valid.
6. x0 write: waddr=0, wen=1 -> rf_wen=0 and C_wen=0 with WRITEBACK_X0_FILTER_EN defined; rf_wen=1 without it.
